// File: rtl/finn_feeder_mul_pkg.sv
// Shared widths and helpers for the FINN feeder multiplier arbiter.
// Optional pipeline stage is selected with FINN_FEEDER_MUL_PIPE_EN in the top module.
package finn_feeder_mul_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_WIDTH_DEF = 32;
  localparam int B_WIDTH_DEF = 31;
  localparam int P_WIDTH_DEF = 32;

  // Full-precision product width: signed A times zero-extended B (one extra sign bit).
  localparam int PROD_FULL_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF + 1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/finn_feeder_mul_core.sv
// Combinational shared multiplier: signed a times zero-extended unsigned b,
// truncated to the low P_WIDTH bits (P_WIDTH must not exceed A_WIDTH+B_WIDTH+1).
module finn_feeder_mul_core #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 31,
  parameter int P_WIDTH = 32
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  localparam int FW = A_WIDTH + B_WIDTH + 1;

  logic signed [FW-1:0] ax;
  logic signed [FW-1:0] bx;
  logic signed [FW-1:0] full;

  // Both operands are widened to the full width so the low bits are exact.
  assign ax   = {{(B_WIDTH + 1){a[A_WIDTH-1]}}, a};
  assign bx   = {{(A_WIDTH + 1){1'b0}}, b};
  assign full = ax * bx;
  assign p    = full[P_WIDTH-1:0];

endmodule

// File: rtl/finn_feeder_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier; valid/ready on both sides.
// Define FINN_FEEDER_MUL_PIPE_EN to add a registered operand stage (latency 2).
module finn_feeder_mul_arbiter
  import finn_feeder_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]            rsp_id
);

  // Transfers happen when valid and ready are both high at a rising edge of
  // ap_clk; ready never depends on operand data, only on valids and stage state.

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    winner;
  logic               any_valid;
  logic               can_adv;
  logic               accept;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;
  logic [A_WIDTH-1:0] core_a;
  logic [B_WIDTH-1:0] core_b;
  logic [P_WIDTH-1:0] core_p;
  logic               out_valid;
  logic [P_WIDTH-1:0] out_data;
  logic [ID_W-1:0]    out_id;

  // Scan offsets high to low so the closest valid at/after rr_ptr wins.
  always_comb begin
    int idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign accept = any_valid && can_adv && !ap_rst;
  assign sel_a  = req_a[int'(winner)*A_WIDTH +: A_WIDTH];
  assign sel_b  = req_b[int'(winner)*B_WIDTH +: B_WIDTH];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  finn_feeder_mul_core #(
    .A_WIDTH(A_WIDTH),
    .B_WIDTH(B_WIDTH),
    .P_WIDTH(P_WIDTH)
  ) u_core (
    .a(core_a),
    .b(core_b),
    .p(core_p)
  );

`ifdef FINN_FEEDER_MUL_PIPE_EN
  logic               s1_valid;
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic [ID_W-1:0]    s1_id;
  logic               out_adv;

  // Stage 1 may refill whenever it is empty or moving forward, so bubbles collapse.
  assign out_adv = !out_valid || rsp_ready;
  assign can_adv = !s1_valid || out_adv;
  assign core_a  = s1_a;
  assign core_b  = s1_b;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (can_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= winner;
        end
      end
      if (out_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= core_p;
          out_id   <= s1_id;
        end
      end
    end
  end
`else
  assign can_adv = !out_valid || rsp_ready;
  assign core_a  = sel_a;
  assign core_b  = sel_b;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (can_adv) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= core_p;
        out_id   <= winner;
      end
    end
  end
`endif

  assign rsp_valid = out_valid;
  assign rsp_data  = out_data;
  assign rsp_id    = out_id;

endmodule

// File: tb/tb_finn_feeder_mul_arbiter.sv
// Directed bench for finn_feeder_mul_arbiter: vector table plus hand-written
// round-robin, backpressure and mid-stream reset sequences (FINN_FEEDER_MUL_PIPE_EN aware).
module tb_finn_feeder_mul_arbiter;

`ifdef FINN_FEEDER_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         ap_clk;
  logic         ap_rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [123:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [30:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  finn_feeder_mul_arbiter dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [30:0] b);
    req_a[id*32 +: 32] = a;
    req_b[id*31 +: 31] = b;
  endtask

  initial begin
    int served;
    logic [31:0] e;

    vecs[0] = '{2, 32'hFFFF_FFFD, 31'd5,          32'hFFFF_FFF1};
    vecs[1] = '{0, 32'h7FFF_FFFF, 31'd2,          32'hFFFF_FFFE};
    vecs[2] = '{3, 32'h8000_0000, 31'h7FFF_FFFF,  32'h8000_0000};
    vecs[3] = '{1, 32'd7,         31'd6,          32'h0000_002A};
    vecs[4] = '{0, 32'hFFFF_FFFF, 31'h7FFF_FFFF,  32'h8000_0001};
    vecs[5] = '{3, 32'h0001_0000, 31'h0001_0000,  32'h0000_0000};
    vecs[6] = '{1, 32'hFFFF_FFFE, 31'd0,          32'h0000_0000};
    vecs[7] = '{2, 32'd1234,      31'd100,        32'h0001_E208};

    ap_rst    = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 31'd10);

    // reset state
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    // round-robin with all requesters valid from reset
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      exp_q.push_back(32'(k % 4));
      if (k >= LAT) begin
        e = exp_q.pop_front();
        check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rr_rsp_id", 64'(rsp_id), 64'(e));
        check("rr_rsp_data", 64'(rsp_data), 64'((e + 1) * 10));
      end
    end
    @(posedge ap_clk); #1;
    req_valid = 4'h0;
    exp_q.delete();
    repeat (3) @(posedge ap_clk);
    #1;

    // single-request vector table
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = 4'b0001 << vecs[v].id;
      @(negedge ap_clk);
      check("vec_ready", 64'(req_ready), 64'(4'b0001 << vecs[v].id));
      @(posedge ap_clk); #1;
      req_valid = 4'h0;
      repeat (LAT - 1) @(posedge ap_clk);
      @(negedge ap_clk);
      check("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      check("vec_rsp_data", 64'(rsp_data), 64'(vecs[v].exp));
      check("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].id));
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      check("vec_no_dup", 64'(rsp_valid), 64'd0);
      @(posedge ap_clk); #1;
    end

    // backpressure: result held while consumer stalls
    set_req(1, 32'd5, 31'd5);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge ap_clk);
    check("bp_first_grant", 64'(req_ready), 64'b0010);
    repeat (2) @(negedge ap_clk);
    for (int j = 0; j < 5; j++) begin
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_data", 64'(rsp_data), 64'd25);
      check("bp_hold_id", 64'(rsp_id), 64'd1);
      check("bp_ready_low", 64'(req_ready), 64'd0);
      @(negedge ap_clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'b0010);
    served = rsp_valid ? 1 : 0;
    @(posedge ap_clk); #1;
    req_valid = 4'h0;
    for (int j = 0; j < 5; j++) begin
      @(negedge ap_clk);
      if (rsp_valid) served++;
    end
    check("bp_served_count", 64'(served), 64'(LAT + 1));
    @(posedge ap_clk); #1;

    // mid-stream reset with results in flight
    set_req(2, 32'hFFFF_FFFD, 31'd5);
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_rsp_data", 64'(rsp_data), 64'd0);
    check("mrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge ap_clk); #1;
    req_valid = 4'b1100;
    rsp_ready = 1'b1;
    ap_rst    = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge ap_clk);
      if (k == 0) check("mrst_first_grant", 64'(req_ready), 64'b0100);
      if (k == 1) check("mrst_second_grant", 64'(req_ready), 64'b1000);
      if (k < LAT) check("mrst_no_stale", 64'(rsp_valid), 64'd0);
      if (k == LAT) begin
        check("mrst_rsp_valid_after", 64'(rsp_valid), 64'd1);
        check("mrst_rsp_id", 64'(rsp_id), 64'd2);
        check("mrst_rsp_data", 64'(rsp_data), 64'hFFFF_FFF1);
      end
    end
    @(posedge ap_clk); #1;
    req_valid = 4'h0;
    repeat (3) @(posedge ap_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
